// File: rtl/psum_pkg.sv
// psum_pkg: definitions shared by the partial-sum tagger files.
//   INFO_*  : bit positions of the fields in the 32-bit psum info tag word.
//   state_t : tile sequencing FSM states.
package psum_pkg;

  localparam int INFO_W        = 32;
  localparam int INFO_ADDR_MSB = 11;
  localparam int INFO_PASS_BIT = 12;
  localparam int INFO_ID_BIT   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/psum_tagger_if.sv
// psum_tagger_if: the two streams around the tagger.
//   mac_*  : raw MAC words into the tagger (mac_data, mac_vld in; mac_rdy out).
//   psum_* : tagged words out to the psum accumulator (psum_info, psum_data,
//            psum_vld out; psum_rdy in).
// Handshake rule for both streams: a word moves on a rising edge where
// vld & rdy are both high; once vld is raised, the payload is held stable
// and vld stays high until that edge; vld never waits on rdy.
//   master : the side that feeds MAC words and sinks tagged words.
//   slave  : the tagger itself.
interface psum_tagger_if
  import psum_pkg::*;
#(
  parameter int DW = 64
);

  logic [DW-1:0]     mac_data;
  logic              mac_vld;
  logic              mac_rdy;
  logic [INFO_W-1:0] psum_info;
  logic [DW-1:0]     psum_data;
  logic              psum_vld;
  logic              psum_rdy;

  modport master (
    output mac_data, mac_vld, psum_rdy,
    input  mac_rdy, psum_info, psum_data, psum_vld
  );

  modport slave (
    input  mac_data, mac_vld, psum_rdy,
    output mac_rdy, psum_info, psum_data, psum_vld
  );

endinterface

// File: rtl/psum_tag_stage.sv
// psum_tag_stage: one-entry registered valid/ready stage.
//   clk, rst          : clock, synchronous active-high reset (drops the entry).
//   in_vld/in_rdy     : upstream handshake; in_rdy = empty or being unloaded.
//   in_data           : word loaded on in_vld & in_rdy.
//   out_vld/out_rdy   : downstream handshake; out_vld is purely registered.
//   out_data          : registered word, stable while out_vld & ~out_rdy.
module psum_tag_stage #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    // Ready is passed through combinationally so a full stage still streams
    // one word per cycle while the consumer keeps taking them.
    in_rdy = ~vld_q | out_rdy;
    load   = in_vld & in_rdy;
    vld_d  = load | (vld_q & ~out_rdy);
    data_d = load ? in_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/psum_tagger.sv
// psum_tagger: tags MAC result words with psum buffer address, pass flag and
// identity-merge flag, over two passes per output tile (pass 0 writes the
// accumulator buffer, pass 1 reads/adds/forwards).
//   clk, rst      : clock, synchronous active-high reset.
//   cfg_start     : start pulse, honoured in IDLE only.
//   cfg_len       : words per pass minus one.
//   cfg_identity  : set the identity flag on pass-1 words.
//   busy          : FSM not in IDLE.
//   tile_done     : one-cycle pulse once the last pass-1 word has left.
//   dbg_state     : current FSM state.
//   bus (slave)   : MAC input stream and tagged psum output stream.
module psum_tagger
  import psum_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_len,
  input  logic          cfg_identity,
  output logic          busy,
  output logic          tile_done,
  output state_t        dbg_state,
  psum_tagger_if.slave  bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_cnt_q, addr_cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic          ident_q, ident_d;
  logic          tile_done_q, tile_done_d;

  logic              active;
  logic              pass;
  logic              last;
  logic              in_hs;
  logic              mac_rdy;
  logic              stage_in_vld;
  logic              stage_in_rdy;
  logic              out_vld;
  logic [INFO_W-1:0] info_in;
  logic [DW+INFO_W-1:0] out_word;

  always_comb begin
    active       = (state_q == PASS0) || (state_q == PASS1);
    pass         = (state_q == PASS1);
    last         = (addr_cnt_q == len_q);
    stage_in_vld = bus.mac_vld & active;
    mac_rdy      = active & stage_in_rdy;
    in_hs        = bus.mac_vld & mac_rdy;

    info_in                  = '0;
    info_in[INFO_ADDR_MSB:0] = addr_cnt_q;
    info_in[INFO_PASS_BIT]   = pass;
    info_in[INFO_ID_BIT]     = ident_q & pass;
  end

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    len_d       = len_q;
    ident_d     = ident_q;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          len_d      = cfg_len;
          ident_d    = cfg_identity;
          addr_cnt_d = '0;
          state_d    = PASS0;
        end
      end
      PASS0, PASS1: begin
        if (in_hs) begin
          // The counter wraps to 0 at the end of each pass, so pass 1
          // revisits exactly the addresses pass 0 wrote.
          addr_cnt_d = last ? '0 : addr_cnt_q + 1'b1;
          if (last) begin
            state_d = (state_q == PASS0) ? PASS1 : DRAIN;
          end
        end
      end
      DRAIN: begin
        // Only the final pass-1 word can be in the stage here.
        if (out_vld & bus.psum_rdy) begin
          state_d     = IDLE;
          tile_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      len_q       <= '0;
      ident_q     <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      len_q       <= len_d;
      ident_q     <= ident_d;
      tile_done_q <= tile_done_d;
    end
  end

  psum_tag_stage #(.W(DW + INFO_W)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (stage_in_vld),
    .in_rdy   (stage_in_rdy),
    .in_data  ({info_in, bus.mac_data}),
    .out_vld  (out_vld),
    .out_rdy  (bus.psum_rdy),
    .out_data (out_word)
  );

  assign bus.mac_rdy   = mac_rdy;
  assign bus.psum_vld  = out_vld;
  assign bus.psum_info = out_word[DW+INFO_W-1:DW];
  assign bus.psum_data = out_word[DW-1:0];
  assign busy          = (state_q != IDLE);
  assign tile_done     = tile_done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_psum_tagger.sv
module tb_psum_tagger;
  import psum_pkg::*;

  localparam int AW = 12;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_start    = 1'b0;
  logic [AW-1:0] cfg_len      = '0;
  logic          cfg_identity = 1'b0;
  logic          busy;
  logic          tile_done;
  state_t        dbg_state;

  psum_tagger_if #(.DW(DW)) m_if ();

  psum_tagger #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_len      (cfg_len),
    .cfg_identity (cfg_identity),
    .busy         (busy),
    .tile_done    (tile_done),
    .dbg_state    (dbg_state),
    .bus          (m_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DW+31:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int last_hs_cyc = 0;
  int hs_cnt  = 0;
  int td_seen = 0;
  int td_exp  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic           prev_vld = 1'b0;
  logic           prev_rdy = 1'b0;
  logic [31:0]    prev_info = '0;
  logic [DW-1:0]  prev_data = '0;

  always @(negedge clk) begin
    logic [DW+31:0] e;
    if (rst) begin
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (m_if.psum_vld && prev_vld && !prev_rdy) begin
        check("hold_info", {32'h0, m_if.psum_info}, {32'h0, prev_info});
        check("hold_data", m_if.psum_data, prev_data);
      end
      if (m_if.psum_vld && !m_if.psum_rdy)
        check("mac_rdy_bp", {63'h0, m_if.mac_rdy}, 64'h0);
      if (m_if.psum_vld && m_if.psum_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected actual_info=0x%0h required=none", m_if.psum_info);
        end else begin
          e = exp_q.pop_front();
          check("out_info", {32'h0, m_if.psum_info}, {32'h0, e[DW+31:DW]});
          check("out_data", m_if.psum_data, e[DW-1:0]);
        end
        last_hs_cyc = cyc;
        hs_cnt++;
      end
      if (tile_done) td_seen++;
      prev_vld  = m_if.psum_vld;
      prev_rdy  = m_if.psum_rdy;
      prev_info = m_if.psum_info;
      prev_data = m_if.psum_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_tile(input logic [AW-1:0] len, input logic id);
    cfg_len      = len;
    cfg_identity = id;
    cfg_start    = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    check("start_busy", {63'h0, busy}, 64'h1);
    check("start_mac_rdy", {63'h0, m_if.mac_rdy}, 64'h1);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic [31:0] info);
    int n;
    n = 0;
    exp_q.push_back({info, d});
    m_if.mac_vld  = 1'b1;
    m_if.mac_data = d;
    @(negedge clk);
    while (!m_if.mac_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_if.mac_rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=no_mac_rdy required=mac_rdy");
    end
    @(posedge clk);
    #1 m_if.mac_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!tile_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tile_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=no_tile_done required=tile_done");
    end else begin
      td_exp++;
      check("done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
      check("done_busy", {63'h0, busy}, 64'h0);
      check("done_state", {62'h0, dbg_state}, {62'h0, IDLE});
      check("done_q_empty", 64'(exp_q.size()), 64'h0);
    end
  endtask

  task automatic run_tile(input logic [AW-1:0] len, input logic id, input logic [DW-1:0] base);
    logic [31:0] info;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k <= int'(len); k++) begin
        info = 32'(k);
        if (p == 1) info = info | 32'h1000 | (id ? 32'h2000 : 32'h0);
        send_word(base + DW'(p * 8192 + k), info);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs0;
    m_if.mac_vld  = 1'b0;
    m_if.mac_data = '0;
    m_if.psum_rdy = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_tile_done", {63'h0, tile_done}, 64'h0);
    check("rst_mac_rdy", {63'h0, m_if.mac_rdy}, 64'h0);
    check("rst_psum_vld", {63'h0, m_if.psum_vld}, 64'h0);
    check("rst_psum_info", {32'h0, m_if.psum_info}, 64'h0);
    check("rst_psum_data", m_if.psum_data, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic tile: len 3, identity 0, data 0x10..0x17
    start_tile(12'd3, 1'b0);
    hs0 = hs_cnt;
    send_word(64'h10, 32'h0000);
    send_word(64'h11, 32'h0001);
    send_word(64'h12, 32'h0002);
    send_word(64'h13, 32'h0003);
    send_word(64'h14, 32'h1000);
    send_word(64'h15, 32'h1001);
    send_word(64'h16, 32'h1002);
    send_word(64'h17, 32'h1003);
    wait_done();
    check("basic_count", 64'(hs_cnt - hs0), 64'd8);

    // identity tile: len 1, identity 1
    start_tile(12'd1, 1'b1);
    send_word(64'hDEAD_BEEF_0000_0001, 32'h0000);
    send_word(64'hDEAD_BEEF_0000_0002, 32'h0001);
    send_word(64'hDEAD_BEEF_0000_0003, 32'h3000);
    send_word(64'hDEAD_BEEF_0000_0004, 32'h3001);
    wait_done();

    // backpressure: psum_rdy low for 5 cycles during pass 0
    start_tile(12'd3, 1'b0);
    send_word(64'h0123_4567_89AB_CDE0, 32'h0000);
    send_word(64'h0123_4567_89AB_CDE1, 32'h0001);
    m_if.psum_rdy = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 m_if.psum_rdy = 1'b1;
      end
    join_none
    send_word(64'h0123_4567_89AB_CDE2, 32'h0002);
    send_word(64'h0123_4567_89AB_CDE3, 32'h0003);
    send_word(64'h0123_4567_89AB_CDE4, 32'h1000);
    send_word(64'h0123_4567_89AB_CDE5, 32'h1001);
    send_word(64'h0123_4567_89AB_CDE6, 32'h1002);
    send_word(64'h0123_4567_89AB_CDE7, 32'h1003);
    wait_done();

    // full-width address range: 4096 words per pass
    start_tile(12'd4095, 1'b0);
    run_tile(12'd4095, 1'b0, 64'hA000_0000_0000_0000);
    wait_done();

    // single word per pass
    start_tile(12'd0, 1'b1);
    hs0 = hs_cnt;
    send_word(64'h5555_AAAA_5555_AAAA, 32'h0000);
    send_word(64'hAAAA_5555_AAAA_5555, 32'h3000);
    wait_done();
    check("len0_count", 64'(hs_cnt - hs0), 64'd2);

    // cfg_start during PASS1 is ignored
    start_tile(12'd2, 1'b0);
    send_word(64'h70, 32'h0000);
    send_word(64'h71, 32'h0001);
    send_word(64'h72, 32'h0002);
    cfg_len      = 12'd0;
    cfg_identity = 1'b1;
    cfg_start    = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    check("p1_start_state", {62'h0, dbg_state}, {62'h0, PASS1});
    send_word(64'h73, 32'h1000);
    send_word(64'h74, 32'h1001);
    send_word(64'h75, 32'h1002);
    wait_done();

    // cfg_start in the tile_done cycle starts a new tile at addr 0
    start_tile(12'd1, 1'b0);
    send_word(64'h80, 32'h0000);
    send_word(64'h81, 32'h0001);
    send_word(64'h82, 32'h1000);
    send_word(64'h83, 32'h1001);
    wait_done();

    // reset pulsed mid PASS0 drops the pending word, no tile_done
    start_tile(12'd1, 1'b0);
    m_if.psum_rdy = 1'b0;
    m_if.mac_vld  = 1'b1;
    m_if.mac_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    #1 m_if.mac_vld = 1'b0;
    check("midrst_loaded", {63'h0, m_if.psum_vld}, 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_psum_vld", {63'h0, m_if.psum_vld}, 64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_mac_rdy", {63'h0, m_if.mac_rdy}, 64'h0);
    check("midrst_state", {62'h0, dbg_state}, {62'h0, IDLE});
    m_if.psum_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", {63'h0, tile_done}, 64'h0);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("tile_done_count", 64'(td_seen), 64'(td_exp));
    check("final_q_empty", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
